avr_uart_tx_arbiter: RTL and testbench
======================================

Name: avr_uart_tx_arbiter

Overview:
- Shares the single FPGA->AVR serial line (top-level avr_rx) between NUM_REQ on-chip byte producers.
- Round-robin arbitration between requesters; each accepted byte is serialized as 8N1 (start bit, 8 data bits LSB first, stop bit).
- Frame starts are held off while the AVR reports its Rx buffer full (avr_rx_busy).
- Instantiated in mojo_top; its tx output drives avr_rx in place of the high-Z tie-off.

Parameters:
- NUM_REQ, 4, number of requesters, 2..8.
- CLK_PER_BIT, 100, clk cycles per serial bit (50 MHz / 500 kbaud), >= 2.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  requester i has a byte pending.
- req_data  in  8*NUM_REQ  requester i byte at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot; byte i accepted on the edge where req_valid[i] & req_ready[i].
- avr_rx_busy  in  1  AVR Rx buffer full; asynchronous to clk.
- tx  out  1  serial data to AVR; idle high.
- grant_idx  out  clog2(NUM_REQ)  index of the most recently accepted requester.
- busy  out  1  high while a frame is being transmitted.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - tx=1, busy=0, req_ready=0, grant_idx=0.
  - State=IDLE; synchronizer flops=1 (treated as busy).
  - Round-robin pointer = NUM_REQ-1, so requester 0 has top priority first.
- avr_rx_busy passes through a 2-flop synchronizer (busy_s) before use.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If busy_s=0 and any req_valid: winner is the first valid index searched from ptr+1 upward, wrapping.
  - req_ready[winner]=1, combinational from req_valid; all other bits 0.
  - On that edge: capture req_data[winner] into the shift register, grant_idx<=winner, ptr<=winner, bit counter reset, state->START.
- req_ready is 0 in every state except IDLE, and 0 in IDLE while busy_s=1.
- Requester obligations:
  - Hold req_valid and req_data stable until the handshake.
  - Dropping req_valid before the handshake is legal and has no effect.
- START: tx=0 for CLK_PER_BIT cycles, then ->DATA.
- DATA:
  - tx = shift[0]; 8 bits, LSB first, each CLK_PER_BIT cycles.
  - Shift right after each bit; after bit 7 ->STOP.
- STOP: tx=1 for CLK_PER_BIT cycles, then ->IDLE.
- busy=1 throughout START/DATA/STOP (exactly 10*CLK_PER_BIT cycles per frame).
- tx is driven from a register; no combinational glitches.
- Back-to-back: the next handshake may occur in the first IDLE cycle, so start-bit spacing is at least 10*CLK_PER_BIT+1 cycles.
- avr_rx_busy is sampled only in IDLE. Assertion mid-frame never aborts or stretches the current frame.
- Round-robin fairness:
  - The last-granted requester has lowest priority next arbitration.
  - With all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0.
- Single-requester case: the same requester may win consecutive frames.
- Reset mid-frame: tx returns to 1 asynchronously and the in-flight byte is dropped. The partial frame is not resent.
- Bit timer and bit counter sized for the parameters; no wrap beyond terminal count.

Test Plan:
- Single byte (CLK_PER_BIT=4, NUM_REQ=4): req_valid=0001, data 0x55, avr_rx_busy=0.
  - req_ready=0001 for 1 cycle.
  - tx = 0x4, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1x4; busy high exactly 40 cycles; grant_idx=0.
- Fairness: all four req_valid held high, data 0xA0+i.
  - Grants in order 0,1,2,3,0.
  - tx frames carry 0xA0,0xA1,0xA2,0xA3,0xA0; start bits 41 cycles apart.
- Partial set: only requesters 1 and 3 valid after a grant to 1.
  - Next grant 3, then 1; requesters 0 and 2 never readied.
- Flow control: avr_rx_busy=1 with req_valid=0001 for 50 cycles.
  - req_ready stays 0, tx stays 1.
  - Release avr_rx_busy: handshake no earlier than 2 cycles after release.
- Mid-frame busy: raise avr_rx_busy during DATA of a 0x3C frame.
  - Frame completes unchanged.
  - No new req_ready until busy_s clears.
- Reset mid-frame: assert rst_n=0 during DATA bit 3.
  - tx=1 and busy=0 immediately.
  - After release with all valid: first grant is requester 0.

Source files
------------

// File: rtl/avr_uart_tx_arbiter.sv
// Round-robin arbiter that shares the FPGA->AVR serial line between NUM_REQ
// byte producers and serializes each accepted byte as 8N1.
module avr_uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int CLK_PER_BIT = 100,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 avr_rx_busy,
  output logic                 tx,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy
);

  localparam int TMR_W = $clog2(CLK_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       sync_q;
  logic [7:0]       shift_q;
  logic [IDX_W-1:0] ptr_q, winner;
  logic             found, busy_s, bit_tick, load, shift_en, tx_d;

  assign busy_s   = sync_q[1];
  assign bit_tick = (tmr_q == TMR_LAST);

  // First valid requester after the last grant, wrapping around.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_d     = bit_q;
    tx_d      = tx;
    load      = 1'b0;
    shift_en  = 1'b0;
    req_ready = '0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!busy_s && found) begin
          req_ready[winner] = 1'b1;
          load    = 1'b1;
          state_d = START;
          tmr_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tmr_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          tmr_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // tx is registered, so it takes the bit the shift is about to expose.
            bit_d    = bit_q + 3'd1;
            shift_en = 1'b1;
            tx_d     = shift_q[1];
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          tmr_d   = '0;
          tx_d    = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; synchronizer resets to "AVR busy" until proven otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      bit_q     <= '0;
      sync_q    <= 2'b11;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      grant_idx <= '0;
      tx        <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], avr_rx_busy};
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      tx      <= tx_d;
      if (load) begin
        grant_idx <= winner;
        ptr_q     <= winner;
      end
    end
  end

  // Data shift register; contents are only meaningful after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      shift_q <= req_data[8*winner +: 8];
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

endmodule

// File: tb/tb_avr_uart_tx_arbiter.sv
// Bench for avr_uart_tx_arbiter: frame-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_avr_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic          avr_rx_busy = 1'b0;
  logic          tx;
  logic [1:0]    grant_idx;
  logic          busy;

  avr_uart_tx_arbiter #(.NUM_REQ(NR), .CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .avr_rx_busy(avr_rx_busy), .tx(tx),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  bit          tx_hist[$];
  bit          busy_hist[$];
  logic [3:0]  ready_hist[$];
  int          hs_idx[$];
  int          hs_cyc[$];
  logic [3:0]  hs_vec = '0;

  // Reference model state: AVR-busy history, position inside the current
  // frame (-1 when idle), byte on the wire, last grant.
  logic [1:0] m_bs = 2'b11;
  int         m_t = -1;
  logic [7:0] m_byte = '0;
  int         m_ptr = NR - 1;
  int         m_grant = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int frame_bit(logic [7:0] d, int t);
    int b = t / CPB;
    if (b == 0) return 0;
    if (b == 9) return 1;
    return int'(d[b-1]);
  endfunction

  function automatic int frame_of(logic [7:0] d);
    return int'({22'd0, 1'b1, d, 1'b0});
  endfunction

  // Rebuild the 10-bit frame from mid-bit samples after handshake cycle h.
  function automatic int decode(int h);
    int f = 0;
    for (int b = 0; b < 10; b++)
      if (tx_hist[h + 1 + b*CPB + CPB/2]) f |= (1 << b);
    return f;
  endfunction

  function automatic int count_hist(int sel, int lo, int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      case (sel)
        0: n += (tx_hist[i] == 1'b0) ? 1 : 0;
        1: n += (busy_hist[i] == 1'b1) ? 1 : 0;
        default: n += (ready_hist[i] != 4'b0) ? 1 : 0;
      endcase
    end
    return n;
  endfunction

  function automatic logic [3:0] or_ready(int lo, int hi);
    logic [3:0] r = '0;
    for (int i = lo; i <= hi; i++) r |= ready_hist[i];
    return r;
  endfunction

  always @(negedge clk) begin
    logic [3:0] exp_ready;
    int w;
    tx_hist.push_back(tx);
    busy_hist.push_back(busy);
    ready_hist.push_back(req_ready);
    hs_vec = req_ready & req_valid;
    if (hs_vec != 0) begin
      for (int i = 0; i < NR; i++) if (hs_vec[i]) hs_idx.push_back(i);
      hs_cyc.push_back(cyc);
    end
    if (!rst_n) begin
      m_bs = 2'b11; m_t = -1; m_ptr = NR - 1; m_grant = 0;
      chk("reset_tx", int'(tx), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_req_ready", int'(req_ready), 0);
      chk("reset_grant_idx", int'(grant_idx), 0);
    end else begin
      exp_ready = '0;
      w = -1;
      if (m_t < 0 && !m_bs[1]) begin
        for (int k = 1; k <= NR; k++)
          if (w < 0 && req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      chk("tx", int'(tx), (m_t < 0) ? 1 : frame_bit(m_byte, m_t));
      chk("busy", int'(busy), (m_t < 0) ? 0 : 1);
      chk("req_ready", int'(req_ready), int'(exp_ready));
      chk("grant_idx", int'(grant_idx), m_grant);
      m_bs = {m_bs[0], avr_rx_busy};
      if (m_t >= 0) begin
        m_t++;
        if (m_t == FRAME) m_t = -1;
      end else if (w >= 0) begin
        m_t = 0; m_byte = req_data[8*w +: 8]; m_grant = w; m_ptr = w;
      end
    end
    cyc++;
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = '0; avr_rx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Returns 1 ns after the edge that completes handshake number 'target'.
  task automatic wait_hs(input int target, input int budget);
    for (int i = 0; i < budget && hs_idx.size() < target; i++) @(posedge clk);
    #1;
    if (hs_idx.size() < target) chk("handshake_timeout", hs_idx.size(), target);
  endtask

  initial begin
    int base, h, r, s;

    // Single byte 0x55 from requester 0.
    reset_dut();
    base = hs_idx.size();
    req_data = '0; req_data[7:0] = 8'h55; req_valid = 4'b0001;
    wait_hs(base + 1, 20);
    req_valid = '0;
    repeat (45) @(posedge clk); #1;
    h = hs_cyc[base];
    chk("s1_ready_cycles", count_hist(2, h - 3, h + 41), 1);
    chk("s1_busy_cycles", count_hist(1, h + 1, h + 41), 40);
    chk("s1_grant", hs_idx[base], 0);
    chk("s1_grant_idx", int'(grant_idx), 0);
    chk("s1_frame", decode(h), frame_of(8'h55));

    // Fairness with all four requesters continuously valid.
    reset_dut();
    base = hs_idx.size();
    for (int i = 0; i < NR; i++) req_data[8*i +: 8] = 8'(8'hA0 + i);
    req_valid = 4'b1111;
    wait_hs(base + 5, 300);
    req_valid = '0;
    repeat (45) @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("s2_grant_order", hs_idx[base + i], i % NR);
      chk("s2_frame", decode(hs_cyc[base + i]), frame_of(8'(8'hA0 + (i % NR))));
      if (i < 4) chk("s2_start_spacing", hs_cyc[base + i + 1] - hs_cyc[base + i], 41);
    end

    // Partial set: 1 first, then 1 and 3 together.
    reset_dut();
    base = hs_idx.size();
    req_data = '0; req_data[15:8] = 8'h11; req_data[31:24] = 8'h33;
    req_valid = 4'b0010;
    wait_hs(base + 1, 20);
    req_valid = 4'b1010;
    wait_hs(base + 3, 200);
    req_valid = '0;
    repeat (45) @(posedge clk); #1;
    chk("s3_grant0", hs_idx[base], 1);
    chk("s3_grant1", hs_idx[base + 1], 3);
    chk("s3_grant2", hs_idx[base + 2], 1);
    chk("s3_never_ready_0_2", int'(or_ready(hs_cyc[base] - 3, hs_cyc[base + 2] + 41) & 4'b0101), 0);
    chk("s3_frame3", decode(hs_cyc[base + 1]), frame_of(8'h33));

    // Flow control: AVR busy holds off the frame start.
    reset_dut();
    base = hs_idx.size();
    avr_rx_busy = 1'b1;
    req_data = '0; req_data[7:0] = 8'h12; req_valid = 4'b0001;
    s = cyc;
    repeat (50) @(posedge clk); #1;
    avr_rx_busy = 1'b0;
    r = cyc;
    wait_hs(base + 1, 20);
    req_valid = '0;
    repeat (45) @(posedge clk); #1;
    chk("s4_ready_while_busy", count_hist(2, s, r - 1), 0);
    chk("s4_tx_low_while_busy", count_hist(0, s, r - 1), 0);
    chk("s4_release_latency_ge2", int'(hs_cyc[base] - r >= 2), 1);
    chk("s4_frame", decode(hs_cyc[base]), frame_of(8'h12));

    // AVR busy raised mid-frame: frame completes, next start waits.
    reset_dut();
    base = hs_idx.size();
    req_data = '0; req_data[23:16] = 8'h3C; req_valid = 4'b0100;
    wait_hs(base + 1, 20);
    req_data[23:16] = 8'h77;
    repeat (CPB + 2) @(posedge clk); #1;
    avr_rx_busy = 1'b1;
    repeat (50) @(posedge clk); #1;
    avr_rx_busy = 1'b0;
    r = cyc;
    wait_hs(base + 2, 20);
    req_valid = '0;
    repeat (45) @(posedge clk); #1;
    h = hs_cyc[base];
    chk("s5_frame", decode(h), frame_of(8'h3C));
    chk("s5_busy_cycles", count_hist(1, h + 1, h + 41), 40);
    chk("s5_no_ready_until_clear", count_hist(2, h + 1, r + 1), 0);
    chk("s5_release_latency_ge2", int'(hs_cyc[base + 1] - r >= 2), 1);
    chk("s5_next_frame", decode(hs_cyc[base + 1]), frame_of(8'h77));

    // Reset during DATA bit 3 of requester 1's frame.
    reset_dut();
    base = hs_idx.size();
    for (int i = 0; i < NR; i++) req_data[8*i +: 8] = 8'(8'hA0 + i);
    req_valid = 4'b1111;
    wait_hs(base + 2, 200);
    repeat (CPB*4 + 1) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_async_tx", int'(tx), 1);
    chk("s6_async_busy", int'(busy), 0);
    chk("s6_async_grant_idx", int'(grant_idx), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_hs(base + 3, 20);
    req_valid = '0;
    repeat (45) @(posedge clk); #1;
    chk("s6_pre_reset_grant", hs_idx[base + 1], 1);
    chk("s6_first_grant_after_reset", hs_idx[base + 2], 0);
    chk("s6_frame_after_reset", decode(hs_cyc[base + 2]), frame_of(8'hA0));

    // Random traffic with random flow control.
    reset_dut();
    base = hs_idx.size();
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (hs_vec[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_data[8*i +: 8] = 8'($urandom);
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 49) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
      if ($urandom_range(0, 39) == 0) avr_rx_busy = ~avr_rx_busy;
    end
    req_valid = '0;
    repeat (45) @(posedge clk); #1;
    chk("rand_activity", int'(hs_idx.size() - base > 20), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
